// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins, count controls and position/status outputs of quad_decoder.
interface quad_decoder_if #(parameter int WIDTH = 22);
    logic quadA, quadB, quadZ, clr, preset_load, err_clr;
    logic [WIDTH-1:0] preset_val, count;
    logic dir, step, err, index_seen;
    modport master(output quadA, quadB, quadZ, clr, preset_load, preset_val, err_clr,
                   input count, dir, step, err, index_seen);
    modport slave(input quadA, quadB, quadZ, clr, preset_load, preset_val, err_clr,
                  output count, dir, step, err, index_seen);
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronised, glitch-filtered quadrature decoder with 1x/2x/4x signed position count.
module quad_decoder #(
    parameter int WIDTH       = 22,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int X_MODE      = 4,
    parameter int WRAP        = 1,
    parameter int INDEX_CLEAR = 1
) (
    input logic clk,
    input logic nrst,
    quad_decoder_if.slave bus
);
    localparam int ARM = SYNC_STAGES + FILTER_LEN + 1;
    localparam int AW = $clog2(ARM + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    logic [2:0] pin, flt;
    logic [1:0] cur, prv, pc, pp, d;
    logic zc, zp, armed, up, ev, zr, iz, sat;
    logic [AW-1:0] arm_cnt;
    logic [WIDTH-1:0] nxt;
    assign pin = {bus.quadZ, bus.quadB, bus.quadA};
    genvar i;
    for (i = 0; i < 3; i++) begin : g_pin
        logic [SYNC_STAGES-1:0] sy;
        logic [FW-1:0] fc;
        logic f;
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                sy <= '0;
                fc <= '0;
                f  <= 1'b0;
            end else begin
                sy <= {sy[SYNC_STAGES-2:0], pin[i]};
                if (sy[SYNC_STAGES-1] == f) fc <= '0;
                else if (fc == FW'(FILTER_LEN - 1)) begin
                    f  <= sy[SYNC_STAGES-1];
                    fc <= '0;
                end else fc <= fc + 1'b1;
            end
        end
        assign flt[i] = f;
    end
    // Gray position 00,10,11,01 -> 0..3; a difference of 1 is up, 3 is down, 2 is illegal
    always_comb begin
        pc  = {cur[0], ^cur};
        pp  = {prv[0], ^prv};
        d   = pc - pp;
        up  = d == 2'b01;
        ev  = armed && d[0] && (X_MODE == 4 ||
              ((cur[1] ^ prv[1]) && (X_MODE == 2 || !(cur[0] | prv[0]))));
        zr  = armed && zc && !zp;
        iz  = INDEX_CLEAR != 0 && zr;
        sat = WRAP == 0 && bus.count == (up ? MAXV : MINV);
        nxt = sat ? bus.count : up ? bus.count + 1'b1 : bus.count - 1'b1;
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur            <= '0;
            prv            <= '0;
            zc             <= 1'b0;
            zp             <= 1'b0;
            arm_cnt        <= '0;
            armed          <= 1'b0;
            bus.count      <= '0;
            bus.dir        <= 1'b0;
            bus.step       <= 1'b0;
            bus.err        <= 1'b0;
            bus.index_seen <= 1'b0;
        end else begin
            cur            <= {flt[0], flt[1]};
            prv            <= cur;
            zc             <= flt[2];
            zp             <= zc;
            arm_cnt        <= arm_cnt + AW'(arm_cnt != AW'(ARM));
            armed          <= arm_cnt == AW'(ARM);
            bus.step       <= ev && !bus.clr && !bus.preset_load && !iz;
            bus.count      <= bus.clr ? '0 : bus.preset_load ? bus.preset_val : iz ? '0 : ev ? nxt : bus.count;
            bus.dir        <= ev ? up : bus.dir;
            bus.err        <= (armed && d == 2'b10) || (bus.err && !bus.err_clr);
            bus.index_seen <= zr || (bus.index_seen && !bus.err_clr);
        end
    end
endmodule
